// File: rtl/l3_neuron_feeder_pkg.sv
// Shared definitions for the l3 neuron stream front-end: FSM encodings,
// the positive saturation limit and a width helper used by the neuron.
package l3_neuron_feeder_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CAPT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [15:0] MAX_S = 16'h7FFF;

    // Largest positive value of a signed word of the given width.
    function automatic int max_pos(input int w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    endfunction

endpackage

// File: rtl/l3_neuron.sv
// Combinational neuron: y = sat(relu(b + sum(x_i * w_i))), clamped to the
// largest positive WIDTH-bit value.
module l3_neuron
    import l3_neuron_feeder_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic [N*WIDTH-1:0] x,
    input  logic [N*WIDTH-1:0] w,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);
    localparam int PW   = 2 * WIDTH;
    // Wide enough that N+1 full-scale terms can never overflow.
    localparam int ACCW = PW + $clog2(N + 1) + 1;
    localparam logic signed [ACCW-1:0] MAXV = ACCW'(max_pos(WIDTH));

    logic signed [ACCW-1:0] acc_s;
    logic signed [PW-1:0]   prod_s;

    // Multiply-accumulate over all lanes, starting from the bias.
    always_comb begin
        acc_s  = ACCW'($signed(b));
        prod_s = '0;
        for (int i = 0; i < N; i++) begin
            prod_s = PW'($signed(x[i*WIDTH +: WIDTH])) * PW'($signed(w[i*WIDTH +: WIDTH]));
            acc_s  = acc_s + ACCW'(prod_s);
        end
    end

    // ReLU then positive saturation.
    always_comb begin
        y = '0;
        if (acc_s[ACCW-1]) begin
            y = '0;
        end else if (acc_s > MAXV) begin
            y = MAXV[WIDTH-1:0];
        end else begin
            y = acc_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/l3_neuron_feeder.sv
// Stream front-end for l3_neuron: gathers N samples into x, holds the
// programmable weights/bias, and returns the registered result on a stream.
module l3_neuron_feeder
    import l3_neuron_feeder_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic             cfg_err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] CFG_BIAS_ADDR = AW'(N);
    localparam logic [CW-1:0] LAST_CNT      = CW'(N - 1);

    state_e               state_r, state_nx_s;
    logic [CW-1:0]        cnt_r;
    logic [N*WIDTH-1:0]   x_r, w_r;
    logic [WIDTH-1:0]     b_r, nrn_y_s, m_data_r;
    logic                 m_valid_r, cfg_err_r;
    logic                 s_ready_s, accept_s, idle_s, cfg_apply_s, cfg_drop_s;

    l3_neuron #(.N(N), .WIDTH(WIDTH)) u_neuron (
        .x (x_r),
        .w (w_r),
        .b (b_r),
        .y (nrn_y_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && (cnt_r == LAST_CNT)) begin
                    state_nx_s = ST_CAPT;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_CAPT: state_nx_s = ST_OUT;
            ST_OUT: begin
                if (m_ready) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: state_nx_s = ST_FILL;
        endcase
    end

    // Handshake and config decode; a config write steals the input slot.
    always_comb begin
        s_ready_s = 1'b0;
        case (state_r)
            ST_FILL: s_ready_s = !cfg_we && !rst;
            ST_CAPT: s_ready_s = 1'b0;
            ST_OUT:  s_ready_s = 1'b0;
            default: s_ready_s = 1'b0;
        endcase
        idle_s      = (state_r == ST_FILL) && (cnt_r == '0);
        accept_s    = s_valid && s_ready_s;
        cfg_apply_s = cfg_we && idle_s && (cfg_addr <= CFG_BIAS_ADDR);
        cfg_drop_s  = cfg_we && !idle_s && (cfg_addr <= CFG_BIAS_ADDR);
    end

    // Datapath: sample capture, config registers and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            x_r       <= '0;
            w_r       <= '0;
            b_r       <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_drop_s;
            if (cfg_apply_s) begin
                if (cfg_addr == CFG_BIAS_ADDR) begin
                    b_r <= cfg_wdata;
                end
                for (int i = 0; i < N; i++) begin
                    if (cfg_addr == AW'(i)) begin
                        w_r[i*WIDTH +: WIDTH] <= cfg_wdata;
                    end
                end
            end
            if (accept_s) begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_r == CW'(i)) begin
                        x_r[i*WIDTH +: WIDTH] <= s_data;
                    end
                end
                cnt_r <= (cnt_r == LAST_CNT) ? '0 : cnt_r + 1'b1;
            end
            if (state_r == ST_CAPT) begin
                m_data_r  <= nrn_y_s;
                m_valid_r <= 1'b1;
            end else if ((state_r == ST_OUT) && m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign cfg_err = cfg_err_r;
    assign busy    = (cnt_r != '0) || (state_r != ST_FILL);

endmodule

// File: tb/tb_l3_neuron_feeder.sv
// Bench for l3_neuron_feeder: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_l3_neuron_feeder;
    import l3_neuron_feeder_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, cfg_we, cfg_err, s_valid, s_ready, m_valid, m_ready, busy;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_wdata, s_data, m_data;

    always #5 clk = ~clk;

    l3_neuron_feeder #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: weights, bias, current partial vector, result pipeline.
    logic signed [W-1:0] mw [N];
    logic signed [W-1:0] mx [N];
    logic signed [W-1:0] mb;
    int       mcnt;
    bit       pend, mvalid, merr, exp_sr;
    int       delay;
    logic [W-1:0] mres, last_y;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic logic [W-1:0] ref_y();
        longint acc = longint'(mb);
        for (int i = 0; i < N; i++) acc += longint'(mx[i]) * longint'(mw[i]);
        if (acc < 0) return '0;
        if (acc > longint'(MAX_S)) return MAX_S;
        return acc[W-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mw[i] = '0;
            mx[i] = '0;
        end
        mb = '0; mcnt = 0; pend = 0; delay = 0; mvalid = 0; merr = 0;
    endtask

    task automatic model_check();
        exp_sr = !rst && !pend && !cfg_we;
        check_eq("s_ready", s_ready, exp_sr);
        check_eq("m_valid", m_valid, mvalid);
        if (mvalid) check_eq("m_data", m_data, mres);
        check_eq("cfg_err", cfg_err, merr);
        check_eq("busy", busy, (mcnt != 0) || pend);
        if (mvalid && m_ready) last_y = m_data;
    endtask

    task automatic model_update();
        bit idle = (mcnt == 0) && !pend;
        merr = cfg_we && (int'(cfg_addr) <= N) && !idle;
        if (cfg_we && idle) begin
            if (int'(cfg_addr) == N) mb = cfg_wdata;
            for (int i = 0; i < N; i++) if (int'(cfg_addr) == i) mw[i] = cfg_wdata;
        end
        if (pend) begin
            if (mvalid && m_ready) begin
                mvalid = 0;
                pend   = 0;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) mvalid = 1;
            end
        end
        if (s_valid && exp_sr) begin
            for (int i = 0; i < N; i++) if (mcnt == i) mx[i] = s_data;
            mcnt++;
            if (mcnt == N) begin
                mcnt = 0; pend = 1; delay = 1;
                mres = ref_y();
            end
        end
    endtask

    task automatic cycle(input bit we, input int addr, input logic [W-1:0] wd,
                         input bit sv, input logic [W-1:0] sd, input bit mr);
        cfg_we = we; cfg_addr = AW'(addr); cfg_wdata = wd;
        s_valid = sv; s_data = sd; m_ready = mr;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic load(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] a3,
                        input logic [W-1:0] bb);
        logic [W-1:0] v [N];
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        for (int i = 0; i < N; i++) cycle(1'b1, i, v[i], 1'b0, '0, 1'b1);
        cycle(1'b1, N, bb, 1'b0, '0, 1'b1);
    endtask

    task automatic push(input logic [W-1:0] s);
        cycle(1'b0, 0, '0, 1'b1, s, 1'b1);
    endtask

    task automatic drain(input int hold);
        int k = 0;
        while (pend && k < 30) begin
            cycle(1'b0, 0, '0, 1'b0, '0, k >= hold);
            k++;
        end
        cycle(1'b0, 0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1'b0);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_m_data", m_data, 16'h0000);
        check_eq("rst_cfg_err", cfg_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; last_y = '1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic
        load(16'd1, 16'd2, 16'd3, 16'd4, 16'd10);
        last_y = '1;
        push(16'd1); push(16'd1); push(16'd1); push(16'd1);
        drain(0);
        check_eq("basic", last_y, 16'd20);

        // ReLU
        load(16'd1, 16'd1, 16'd1, 16'd1, 16'd0);
        last_y = '1;
        for (int i = 0; i < N; i++) push(16'hFFFB);
        drain(0);
        check_eq("relu", last_y, 16'd0);

        // Saturation
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        last_y = '1;
        for (int i = 0; i < N; i++) push(16'h7FFF);
        drain(0);
        check_eq("saturate", last_y, 16'h7FFF);

        // Backpressure
        load(16'd1, 16'd1, 16'd1, 16'd1, 16'd0);
        last_y = '1;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        drain(7);
        check_eq("backpressure", last_y, 16'd10);

        // Config while busy, then at idle
        last_y = '1;
        push(16'd5); push(16'd5);
        cycle(1'b1, 0, 16'd9, 1'b0, '0, 1'b1);
        push(16'd5); push(16'd5);
        drain(0);
        check_eq("cfg_busy_result", last_y, 16'd20);
        cycle(1'b1, 0, 16'd9, 1'b0, '0, 1'b1);
        cycle(1'b1, 7, 16'd3, 1'b0, '0, 1'b1);
        last_y = '1;
        for (int i = 0; i < N; i++) push(16'd1);
        drain(0);
        check_eq("cfg_idle_result", last_y, 16'd12);

        // Reset mid-fill
        push(16'd7); push(16'd7);
        do_reset();
        last_y = '1;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        drain(0);
        check_eq("rst_weights_zero", last_y, 16'd0);
        load(16'd1, 16'd1, 16'd1, 16'd1, 16'd0);
        last_y = '1;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        drain(0);
        check_eq("rst_reload", last_y, 16'd10);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bit we = ($urandom_range(0, 9) == 0);
            int ad = int'($urandom_range(0, 7));
            logic [W-1:0] wd;
            logic [W-1:0] sd;
            if ($urandom_range(0, 1) == 0) wd = W'(int'($urandom_range(0, 20)) - 10);
            else wd = W'($urandom);
            if ($urandom_range(0, 1) == 0) sd = W'(int'($urandom_range(0, 40)) - 20);
            else sd = W'($urandom);
            cycle(we, ad, wd, $urandom_range(0, 9) < 7, sd, $urandom_range(0, 9) < 6);
        end
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
